// File: rtl/seg7_scan_driver_if.sv
// Game-FSM side of the 7-segment scan driver: code/load inputs and board pin outputs.
interface seg7_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      en;
    logic                      mode;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   codes;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [6:0]                seg;
    logic [NUM_DIGITS-1:0]     dig;
    logic                      frame_tick;

    // Code source (game FSM or bench) drives the controls and reads the pins.
    modport master (
        output en, mode, load, codes, blink_mask,
        input  seg, dig, frame_tick
    );

    // The scan driver consumes the controls and drives the pins.
    modport slave (
        input  en, mode, load, codes, blink_mask,
        output seg, dig, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: per-digit decode, attack-mode blink,
// blank interval between digits and frame-synchronous code updates.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_DIV    = 64,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg7_scan_driver_if.slave     bus
);

    localparam int unsigned SCAN_CYCLES = REFRESH_DIV - BLANK_CYCLES;
    localparam int unsigned CNT_W       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned FRM_W       = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned CODE_W      = 4 * NUM_DIGITS;
    localparam bit          INVERT      = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    // Active-high segment pattern {g,f,e,d,c,b,a} for one 4-bit code.
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            4'd10:   s = 7'b1110111;
            4'd11:   s = 7'b1111100;
            4'd12:   s = 7'b0111001;
            4'd13:   s = 7'b1011110;
            4'd14:   s = 7'b1111001;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    state_t                state, state_nx;
    logic [CNT_W-1:0]      cnt, cnt_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic                  frame_start;

    logic [CODE_W-1:0]     shadow_codes, shadow_codes_nx;
    logic [NUM_DIGITS-1:0] shadow_blink, shadow_blink_nx;
    logic [CODE_W-1:0]     pend_codes;
    logic [NUM_DIGITS-1:0] pend_blink;
    logic                  pend_valid, pend_valid_nx;
    logic [FRM_W-1:0]      frame_cnt, frame_cnt_nx;
    logic                  phase_hidden, phase_hidden_nx;

    logic [6:0]            seg_nx, seg_q;
    logic [NUM_DIGITS-1:0] dig_nx, dig_q;
    logic                  tick_q;

    // State register: FSM position plus the registered pin outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            seg_q  <= INVERT ? 7'h7F : 7'h00;
            dig_q  <= INVERT ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
            tick_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            seg_q  <= seg_nx;
            dig_q  <= dig_nx;
            tick_q <= frame_start;
        end
    end

    // Next-state: slot timing, digit rotation and frame-start detection.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        idx_nx      = idx;
        frame_start = 1'b0;
        if (!bus.en) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx    = SCAN;
                    cnt_nx      = '0;
                    idx_nx      = '0;
                    frame_start = 1'b1;
                end
                SCAN: begin
                    cnt_nx = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(SCAN_CYCLES - 1)) begin
                        state_nx = BLANK;
                    end
                end
                BLANK: begin
                    if (cnt == CNT_W'(REFRESH_DIV - 1)) begin
                        state_nx = SCAN;
                        cnt_nx   = '0;
                        if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                            idx_nx      = '0;
                            frame_start = 1'b1;
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Frame-synchronous shadow update, blink phase counter and pending-load tracking.
    always_comb begin
        shadow_codes_nx = shadow_codes;
        shadow_blink_nx = shadow_blink;
        frame_cnt_nx    = frame_cnt;
        phase_hidden_nx = phase_hidden;
        pend_valid_nx   = pend_valid;
        if (frame_start) begin
            if (pend_valid) begin
                shadow_codes_nx = pend_codes;
                shadow_blink_nx = pend_blink;
            end
            pend_valid_nx = 1'b0;
            if (frame_cnt == FRM_W'(BLINK_DIV - 1)) begin
                frame_cnt_nx    = '0;
                phase_hidden_nx = ~phase_hidden;
            end else begin
                frame_cnt_nx = frame_cnt + FRM_W'(1);
            end
        end
        // A load on a frame-start cycle stays pending for the following frame.
        if (bus.load) begin
            pend_valid_nx = 1'b1;
        end
    end

    // Output decode from the upcoming state so pins reflect the decision at this edge.
    always_comb begin
        logic [3:0]            code;
        logic                  blink_bit;
        logic [6:0]            seg_on;
        logic [NUM_DIGITS-1:0] dig_on;
        code      = 4'hF;
        blink_bit = 1'b0;
        seg_on    = 7'b0000000;
        dig_on    = '0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_nx == IDX_W'(i)) begin
                code      = shadow_codes_nx[4*i +: 4];
                blink_bit = shadow_blink_nx[i];
            end
        end
        if (state_nx == SCAN) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                dig_on[i] = (idx_nx == IDX_W'(i));
            end
            if (!(bus.mode && blink_bit && phase_hidden_nx)) begin
                seg_on = decode(code);
            end
        end
        seg_nx = INVERT ? ~seg_on : seg_on;
        dig_nx = INVERT ? ~dig_on : dig_on;
    end

    // Shadow, pending and blink registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_codes <= {NUM_DIGITS{4'hF}};
            shadow_blink <= '0;
            pend_codes   <= {NUM_DIGITS{4'hF}};
            pend_blink   <= '0;
            pend_valid   <= 1'b0;
            frame_cnt    <= '0;
            phase_hidden <= 1'b0;
        end else begin
            shadow_codes <= shadow_codes_nx;
            shadow_blink <= shadow_blink_nx;
            pend_valid   <= pend_valid_nx;
            frame_cnt    <= frame_cnt_nx;
            phase_hidden <= phase_hidden_nx;
            if (bus.load) begin
                pend_codes <= bus.codes;
                pend_blink <= bus.blink_mask;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dig        = dig_q;
    assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 2-digit, 16-cycle-frame configuration.
module tb_seg7_scan_driver;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_E   = 7'b0000110;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    int   gap;

    seg7_scan_driver_if #(.NUM_DIGITS(2)) bus ();

    seg7_scan_driver #(
        .NUM_DIGITS  (2),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2),
        .BLINK_DIV   (2),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic advance(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Ticks until frame_tick is seen; returns the tick count or -1 on timeout.
    task automatic wait_frame(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (bus.frame_tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset           = 1'b1;
        bus.en          = 1'b0;
        bus.mode        = 1'b0;
        bus.load        = 1'b0;
        bus.codes       = 8'hFF;
        bus.blink_mask  = 2'b00;
        advance(3);
        check("reset_seg", 32'(bus.seg), 32'(SEG_OFF));
        check("reset_dig", 32'(bus.dig), 32'(2'b11));
        check("reset_tick", 32'(bus.frame_tick), 32'd0);

        reset = 1'b0;
        tick();
        check("idle_dig", 32'(bus.dig), 32'(2'b11));

        // First frame after enable: digit0 slot, then blank, then digit1.
        bus.en = 1'b1;
        tick();
        check("first_dig", 32'(bus.dig), 32'(2'b10));
        check("first_seg", 32'(bus.seg), 32'(SEG_OFF));
        check("first_tick", 32'(bus.frame_tick), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("scan0_dig", 32'(bus.dig), 32'(2'b10));
            check("scan0_tick", 32'(bus.frame_tick), 32'd0);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            check("blank_dig", 32'(bus.dig), 32'(2'b11));
            check("blank_seg", 32'(bus.seg), 32'(SEG_OFF));
        end
        tick();
        check("scan1_dig", 32'(bus.dig), 32'(2'b01));
        wait_frame(gap);
        check("gap_half", 32'(gap), 32'd8);

        // Load C/A mid-frame; shown only from the next frame start.
        bus.codes = 8'hCA;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
        check("midframe_seg", 32'(bus.seg), 32'(SEG_OFF));
        wait_frame(gap);
        check("gap_load", 32'(gap), 32'd15);
        check("load_d0_seg", 32'(bus.seg), 32'(SEG_A));
        check("load_d0_dig", 32'(bus.dig), 32'(2'b10));
        advance(8);
        check("load_d1_dig", 32'(bus.dig), 32'(2'b01));
        check("load_d1_seg", 32'(bus.seg), 32'(SEG_C));

        // Two loads in one frame: last one wins.
        bus.codes = 8'hC3;
        bus.load  = 1'b1;
        tick();
        bus.codes = 8'hCE;
        tick();
        bus.load  = 1'b0;
        check("dbl_mid_seg", 32'(bus.seg), 32'(SEG_C));
        wait_frame(gap);
        check("gap_dbl", 32'(gap), 32'd6);
        check("dbl_d0_seg", 32'(bus.seg), 32'(SEG_E));

        // Blink on digit0 in attack mode (this is frame 4, phase visible).
        bus.mode       = 1'b1;
        bus.codes      = 8'hCA;
        bus.blink_mask = 2'b01;
        bus.load       = 1'b1;
        tick();
        bus.load       = 1'b0;
        wait_frame(gap);
        check("f5_seg", 32'(bus.seg), 32'(SEG_A));
        wait_frame(gap);
        check("gap_full", 32'(gap), 32'd16);
        check("f6_hidden", 32'(bus.seg), 32'(SEG_OFF));
        check("f6_dig", 32'(bus.dig), 32'(2'b10));
        advance(8);
        check("f6_d1_seg", 32'(bus.seg), 32'(SEG_C));
        wait_frame(gap);
        check("f7_hidden", 32'(bus.seg), 32'(SEG_OFF));
        wait_frame(gap);
        check("f8_visible", 32'(bus.seg), 32'(SEG_A));
        wait_frame(gap);
        check("f9_visible", 32'(bus.seg), 32'(SEG_A));
        wait_frame(gap);
        check("f10_hidden", 32'(bus.seg), 32'(SEG_OFF));

        // mode=0 suppresses blink while the phase counter keeps running.
        bus.mode = 1'b0;
        tick();
        check("mode0_seg", 32'(bus.seg), 32'(SEG_A));
        wait_frame(gap);
        check("f11_mode0", 32'(bus.seg), 32'(SEG_A));
        bus.mode = 1'b1;
        tick();
        check("f11_hidden", 32'(bus.seg), 32'(SEG_OFF));

        // Drop enable during digit1 scan, then restart.
        advance(8);
        check("pre_drop_dig", 32'(bus.dig), 32'(2'b01));
        bus.en = 1'b0;
        tick();
        check("drop_dig", 32'(bus.dig), 32'(2'b11));
        check("drop_seg", 32'(bus.seg), 32'(SEG_OFF));
        advance(3);
        check("idle_hold_dig", 32'(bus.dig), 32'(2'b11));
        bus.en = 1'b1;
        tick();
        check("restart_dig", 32'(bus.dig), 32'(2'b10));
        check("restart_tick", 32'(bus.frame_tick), 32'd1);
        check("restart_seg", 32'(bus.seg), 32'(SEG_A));
        advance(8);
        check("restart_d1_seg", 32'(bus.seg), 32'(SEG_C));

        // Reset with a pending load: the load is discarded.
        bus.codes      = 8'h33;
        bus.blink_mask = 2'b00;
        bus.load       = 1'b1;
        tick();
        bus.load       = 1'b0;
        reset          = 1'b1;
        tick();
        check("rst2_dig", 32'(bus.dig), 32'(2'b11));
        check("rst2_seg", 32'(bus.seg), 32'(SEG_OFF));
        reset = 1'b0;
        tick();
        check("rst2_tick", 32'(bus.frame_tick), 32'd1);
        check("rst2_d0_seg", 32'(bus.seg), 32'(SEG_OFF));
        advance(8);
        check("rst2_d1_dig", 32'(bus.dig), 32'(2'b01));
        check("rst2_d1_seg", 32'(bus.seg), 32'(SEG_OFF));
        wait_frame(gap);
        check("rst2_gap", 32'(gap), 32'd8);
        check("rst2_f2_seg", 32'(bus.seg), 32'(SEG_OFF));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
